excp_commit_ctrl: RTL and testbench
===================================

Name: excp_commit_ctrl

Overview:
- Commit-stage exception/interrupt sequencer for the dual-issue MIPS pipeline.
- Each cycle, picks the architecturally oldest event from two commit slots plus the pending interrupt, and issues one CP0 exception/ERET command.
- Kills younger slots, then drives a registered flush/redirect to fetch.
- Owns interrupt deferral when no instruction is committing, so CP0 itself stays a pure register file.

Parameters:
- EXC_VEC, 32'hBFC0_0380, general exception vector for redirect.
- DEFER_MAX, 8, max idle cycles an interrupt waits for a committing instruction before it is taken on the tracked next PC.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- commit_valid  in  2  slot i holds a retiring instruction; slot 0 is older
- commit_pc  in  2x32  PC per slot
- commit_in_ds  in  2  slot instruction sits in a branch delay slot
- commit_exc  in  2  slot raised a synchronous exception
- commit_exccode  in  2x5  ExcCode per slot (already prioritised upstream)
- commit_badv_we  in  2  exception carries a BadVAddr
- commit_badv  in  2x32  BadVAddr value
- commit_eret  in  2  slot is ERET
- int_pending  in  1  CP0 unmasked interrupt (already gated by IE/!EXL)
- cp0_exl  in  1  current Status.EXL
- cp0_epc  in  32  current EPC
- commit_kill  out  2  combinational; slot must not retire this cycle
- cp0_excp_we  out  1  combinational; CP0 takes exception at this edge
- cp0_exccode  out  5  ExcCode to write
- cp0_epc_wd  out  32  EPC to write (ignored by CP0 when EXL=1)
- cp0_bd  out  1  Cause.BD
- cp0_badv_we  out  1  write BadVAddr
- cp0_badv_wd  out  32  BadVAddr value
- cp0_eret  out  1  combinational; clear EXL at this edge
- flush  out  1  registered; one-cycle pipeline flush
- redirect_valid  out  1  registered; same cycle as flush
- redirect_pc  out  32  registered target

Behaviour:
- Reset: state IDLE; all outputs 0; last_pc=32'hBFC0_0000; defer_cnt=0.
- States: IDLE, INT_WAIT, FLUSH.
- IDLE/INT_WAIT event pick, first match wins:
  - int_pending with slot0 valid: INT(0) on slot 0.
  - int_pending with only slot1 valid: INT(0) on slot 1.
  - commit_exc[0]: exception on slot 0.
  - commit_eret[0]: ERET on slot 0.
  - commit_exc[1]: exception on slot 1.
  - commit_eret[1]: ERET on slot 1.
- Chosen slot k: commit_kill[j]=1 for all j>=k that are valid; an exception/INT slot is itself killed; slot 0 retires when k=1.
- Exception/INT command: cp0_excp_we=1.
  - EPC = pc-4 and bd=1 if in_ds, else EPC = pc and bd=0.
  - badv_we/wd from the slot, forced 0 for INT.
  - Next cycle: flush=1, redirect_pc=EXC_VEC.
- ERET command: cp0_eret=1. Next cycle: flush=1, redirect_pc = cp0_epc sampled in the ERET cycle.
- Any event: next state FLUSH for exactly 1 cycle. In FLUSH, commit_kill=2'b11 and no CP0 command is issued; then go to IDLE.
- int_pending with no valid slot in IDLE: go to INT_WAIT, defer_cnt=0.
- INT_WAIT:
  - A commit arriving takes INT per the rules above.
  - int_pending deasserting returns to IDLE.
  - If defer_cnt reaches DEFER_MAX-1, take INT with EPC = last_pc+4 and bd=0.
  - Width: 32-bit wrap on +4/-4.
- last_pc updates to the PC of the youngest retiring (non-killed) slot.
- cp0_exl=1: the exception is still taken, ExcCode/badv are written, and EPC is still driven but CP0 ignores it.
- Reset mid-FLUSH: the pending redirect is dropped.

Optional Feature:
- Macro EXCP_CTRL_PERF_EN.
- When defined:
  - Adds outputs perf_exc_cnt (32), perf_int_cnt (32), perf_defer_cnt (32).
  - Counters increment on exception, INT, and deferred-INT commands; saturate at all-ones; reset to 0.
- When undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package excp_pkg:
  - ExcCode constants (INT=0, ADEL=4, ADES=5, SYS=8, BP=9, RI=10, OV=12).
  - State enum.
  - Struct excp_cmd_t {we, exccode, epc, bd, badv_we, badv, eret}.
- Sub-module excp_slot_pick: combinational priority select producing chosen slot, kind and kill mask.

Test Plan:
- Slot0 valid, pc=0x80001000, commit_exc[0]=1, code=12, slot1 valid: kill=11, excp_we=1, code=12, EPC=0x80001000, bd=0; next cycle flush=1, redirect_pc=0xBFC00380; following cycle kill=11.
- Slot0 clean pc=0x100, slot1 in_ds pc=0x104 with ADEL badv=0x3: kill=10, EPC=0x100, bd=1, badv_we=1, badv=0x3.
- int_pending with slot0 ERET pc=0x200: INT wins, code=0, EPC=0x200, eret=0.
- ERET slot0 with cp0_epc=0x80002000: cp0_eret=1, kill=11; next cycle redirect_pc=0x80002000.
- Last retire pc=0x300, then int_pending with no commits, DEFER_MAX=8: INT_WAIT for 7 cycles, 8th cycle excp_we=1, EPC=0x304.
- Reset asserted in FLUSH: next cycle flush=0, state IDLE, all outputs 0.

Source files
------------

// File: rtl/excp_pkg.sv
// Shared types for the commit-stage exception sequencer: ExcCodes, FSM states,
// event kinds and the CP0 command bundle.
package excp_pkg;

    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_SYS  = 5'd8;
    localparam logic [4:0] EXC_BP   = 5'd9;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

    typedef enum logic [1:0] {ST_IDLE, ST_INT_WAIT, ST_FLUSH} excp_state_t;

    typedef enum logic [1:0] {EV_NONE, EV_INT, EV_EXC, EV_ERET} excp_event_t;

    typedef struct packed {
        logic        we;
        logic [4:0]  exccode;
        logic [31:0] epc;
        logic        bd;
        logic        badv_we;
        logic [31:0] badv;
        logic        eret;
    } excp_cmd_t;

endpackage

// File: rtl/excp_slot_pick.sv
// Age-ordered event picker for the two commit slots: an interrupt binds to the
// oldest valid slot, otherwise the oldest exception/ERET wins.
module excp_slot_pick
    import excp_pkg::*;
(
    input  logic [1:0]  i_valid,
    input  logic [1:0]  i_exc,
    input  logic [1:0]  i_eret,
    input  logic        i_int_pending,
    output excp_event_t o_kind,
    output logic        o_slot,
    output logic [1:0]  o_kill
);

    logic [1:0] w_exc;
    logic [1:0] w_eret;

    assign w_exc  = i_valid & i_exc;
    assign w_eret = i_valid & i_eret;

    always_comb begin
        o_kind = EV_NONE;
        o_slot = 1'b0;
        if (i_int_pending && i_valid[0]) begin
            o_kind = EV_INT;
        end else if (i_int_pending && i_valid[1]) begin
            o_kind = EV_INT;
            o_slot = 1'b1;
        end else if (w_exc[0]) begin
            o_kind = EV_EXC;
        end else if (w_eret[0]) begin
            o_kind = EV_ERET;
        end else if (w_exc[1]) begin
            o_kind = EV_EXC;
            o_slot = 1'b1;
        end else if (w_eret[1]) begin
            o_kind = EV_ERET;
            o_slot = 1'b1;
        end
    end

    // The chosen slot and every younger valid slot are squashed.
    assign o_kill = (o_kind == EV_NONE) ? 2'b00 :
                    (o_slot ? {i_valid[1], 1'b0} : i_valid);

endmodule

// File: rtl/excp_commit_ctrl.sv
// Commit-stage exception/interrupt sequencer: issues one CP0 command per event,
// then a registered flush/redirect. Optional counters under EXCP_CTRL_PERF_EN.
module excp_commit_ctrl
    import excp_pkg::*;
#(
    parameter logic [31:0] EXC_VEC   = 32'hBFC0_0380,
    parameter int          DEFER_MAX = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  commit_valid,
    input  logic [63:0] commit_pc,
    input  logic [1:0]  commit_in_ds,
    input  logic [1:0]  commit_exc,
    input  logic [9:0]  commit_exccode,
    input  logic [1:0]  commit_badv_we,
    input  logic [63:0] commit_badv,
    input  logic [1:0]  commit_eret,
    input  logic        int_pending,
    input  logic        cp0_exl,
    input  logic [31:0] cp0_epc,
    output logic [1:0]  commit_kill,
    output logic        cp0_excp_we,
    output logic [4:0]  cp0_exccode,
    output logic [31:0] cp0_epc_wd,
    output logic        cp0_bd,
    output logic        cp0_badv_we,
    output logic [31:0] cp0_badv_wd,
    output logic        cp0_eret,
    output logic        flush,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc
`ifdef EXCP_CTRL_PERF_EN
    ,
    output logic [31:0] perf_exc_cnt,
    output logic [31:0] perf_int_cnt,
    output logic [31:0] perf_defer_cnt
`endif
);

    localparam int          CNT_W    = $clog2(DEFER_MAX) + 1;
    localparam logic [31:0] RESET_PC = 32'hBFC0_0000;

    excp_state_t      r_state;
    excp_state_t      w_next_state;
    logic [CNT_W-1:0] r_defer_cnt;
    logic [31:0]      r_last_pc;
    logic             r_flush;
    logic             r_redirect_valid;
    logic [31:0]      r_redirect_pc;

    excp_event_t w_pick_kind;
    logic        w_pick_slot;
    logic [1:0]  w_pick_kill;
    logic        w_take_defer;
    logic        w_event;
    excp_cmd_t   w_cmd;
    logic [1:0]  w_kill;
    logic [1:0]  w_retire;
    logic [31:0] w_slot_pc;
    logic [31:0] w_slot_badv;
    logic [4:0]  w_slot_code;
    logic        w_slot_ds;
    logic        w_slot_badv_we;
    logic        w_unused_exl;

    // EXL only changes how CP0 treats EPC; the sequencing is identical.
    assign w_unused_exl = cp0_exl;

    excp_slot_pick u_pick (
        .i_valid       (commit_valid),
        .i_exc         (commit_exc),
        .i_eret        (commit_eret),
        .i_int_pending (int_pending),
        .o_kind        (w_pick_kind),
        .o_slot        (w_pick_slot),
        .o_kill        (w_pick_kill)
    );

    assign w_slot_pc      = w_pick_slot ? commit_pc[63:32]     : commit_pc[31:0];
    assign w_slot_badv    = w_pick_slot ? commit_badv[63:32]   : commit_badv[31:0];
    assign w_slot_code    = w_pick_slot ? commit_exccode[9:5]  : commit_exccode[4:0];
    assign w_slot_ds      = w_pick_slot ? commit_in_ds[1]      : commit_in_ds[0];
    assign w_slot_badv_we = w_pick_slot ? commit_badv_we[1]    : commit_badv_we[0];

    assign w_take_defer = (r_state == ST_INT_WAIT) && int_pending &&
                          (w_pick_kind == EV_NONE) &&
                          (r_defer_cnt == CNT_W'(DEFER_MAX - 1));

    always_comb begin
        w_next_state = r_state;
        w_cmd        = '0;
        w_kill       = 2'b00;
        w_event      = 1'b0;
        if (!reset) begin
            case (r_state)
                ST_FLUSH: begin
                    w_kill       = 2'b11;
                    w_next_state = ST_IDLE;
                end
                default: begin
                    if (w_pick_kind != EV_NONE) begin
                        w_event      = 1'b1;
                        w_kill       = w_pick_kill;
                        w_next_state = ST_FLUSH;
                        if (w_pick_kind == EV_ERET) begin
                            w_cmd.eret = 1'b1;
                        end else begin
                            w_cmd.we      = 1'b1;
                            w_cmd.exccode = (w_pick_kind == EV_INT) ? EXC_INT : w_slot_code;
                            w_cmd.epc     = w_slot_ds ? w_slot_pc - 32'd4 : w_slot_pc;
                            w_cmd.bd      = w_slot_ds;
                            if (w_pick_kind == EV_EXC) begin
                                w_cmd.badv_we = w_slot_badv_we;
                                w_cmd.badv    = w_slot_badv;
                            end
                        end
                    end else if (w_take_defer) begin
                        // Nothing committed in time: resume after the last retired PC.
                        w_event       = 1'b1;
                        w_cmd.we      = 1'b1;
                        w_cmd.exccode = EXC_INT;
                        w_cmd.epc     = r_last_pc + 32'd4;
                        w_next_state  = ST_FLUSH;
                    end else if (int_pending) begin
                        w_next_state = ST_INT_WAIT;
                    end else begin
                        w_next_state = ST_IDLE;
                    end
                end
            endcase
        end
    end

    assign w_retire = (r_state == ST_FLUSH) ? 2'b00 : (commit_valid & ~w_kill);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state          <= ST_IDLE;
            r_defer_cnt      <= '0;
            r_last_pc        <= RESET_PC;
            r_flush          <= 1'b0;
            r_redirect_valid <= 1'b0;
            r_redirect_pc    <= 32'd0;
        end else begin
            r_state          <= w_next_state;
            r_defer_cnt      <= (r_state == ST_INT_WAIT && w_next_state == ST_INT_WAIT) ?
                                r_defer_cnt + CNT_W'(1) : '0;
            r_flush          <= w_event;
            r_redirect_valid <= w_event;
            if (w_event) begin
                r_redirect_pc <= w_cmd.eret ? cp0_epc : EXC_VEC;
            end
            if (w_retire[1]) begin
                r_last_pc <= commit_pc[63:32];
            end else if (w_retire[0]) begin
                r_last_pc <= commit_pc[31:0];
            end
        end
    end

    assign commit_kill    = w_kill;
    assign cp0_excp_we    = w_cmd.we;
    assign cp0_exccode    = w_cmd.exccode;
    assign cp0_epc_wd     = w_cmd.epc;
    assign cp0_bd         = w_cmd.bd;
    assign cp0_badv_we    = w_cmd.badv_we;
    assign cp0_badv_wd    = w_cmd.badv;
    assign cp0_eret       = w_cmd.eret;
    assign flush          = r_flush;
    assign redirect_valid = r_redirect_valid;
    assign redirect_pc    = r_redirect_pc;

`ifdef EXCP_CTRL_PERF_EN
    logic [31:0] r_perf_exc;
    logic [31:0] r_perf_int;
    logic [31:0] r_perf_defer;
    logic        w_cnt_exc;
    logic        w_cnt_int;

    assign w_cnt_exc = w_event && (w_pick_kind == EV_EXC);
    assign w_cnt_int = w_cmd.we && !w_cnt_exc;

    // Saturating counters; the deferred count is a subset of the INT count.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_perf_exc   <= 32'd0;
            r_perf_int   <= 32'd0;
            r_perf_defer <= 32'd0;
        end else begin
            if (w_cnt_exc && r_perf_exc != '1) begin
                r_perf_exc <= r_perf_exc + 32'd1;
            end
            if (w_cnt_int && r_perf_int != '1) begin
                r_perf_int <= r_perf_int + 32'd1;
            end
            if (w_take_defer && r_perf_defer != '1) begin
                r_perf_defer <= r_perf_defer + 32'd1;
            end
        end
    end

    assign perf_exc_cnt   = r_perf_exc;
    assign perf_int_cnt   = r_perf_int;
    assign perf_defer_cnt = r_perf_defer;
`endif

endmodule

// File: tb/tb_excp_commit_ctrl.sv
// Self-checking bench for excp_commit_ctrl: directed scenarios plus a randomized
// run against an age-ordered behavioural model of the commit sequencer.
module tb_excp_commit_ctrl;

    localparam int DEFER_MAX = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  commit_valid, commit_in_ds, commit_exc, commit_badv_we, commit_eret;
    logic [63:0] commit_pc, commit_badv;
    logic [9:0]  commit_exccode;
    logic        int_pending, cp0_exl;
    logic [31:0] cp0_epc;
    logic [1:0]  commit_kill;
    logic        cp0_excp_we, cp0_bd, cp0_badv_we, cp0_eret, flush, redirect_valid;
    logic [4:0]  cp0_exccode;
    logic [31:0] cp0_epc_wd, cp0_badv_wd, redirect_pc;

    int checks = 0;
    int failures = 0;

    // Model state: inside flush window, cycles spent waiting (-1 = not waiting),
    // last retired PC, and the registered outputs expected this cycle.
    bit          mInFlush;
    int          mWait;
    logic [31:0] mLastPc;
    logic        mFlush;
    logic [31:0] mRedirPc;
    logic [1:0]  eKill;
    logic        eWe, eEret, eBd, eBadvWe, eEvent;
    logic [4:0]  eCode;
    logic [31:0] eEpc, eBadv;

    excp_commit_ctrl dut (
        .clk(clk), .reset(reset),
        .commit_valid(commit_valid), .commit_pc(commit_pc), .commit_in_ds(commit_in_ds),
        .commit_exc(commit_exc), .commit_exccode(commit_exccode),
        .commit_badv_we(commit_badv_we), .commit_badv(commit_badv), .commit_eret(commit_eret),
        .int_pending(int_pending), .cp0_exl(cp0_exl), .cp0_epc(cp0_epc),
        .commit_kill(commit_kill), .cp0_excp_we(cp0_excp_we), .cp0_exccode(cp0_exccode),
        .cp0_epc_wd(cp0_epc_wd), .cp0_bd(cp0_bd), .cp0_badv_we(cp0_badv_we),
        .cp0_badv_wd(cp0_badv_wd), .cp0_eret(cp0_eret), .flush(flush),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
    );

    always #5 clk = ~clk;

    task automatic clearInputs();
        commit_valid = '0; commit_pc = '0; commit_in_ds = '0; commit_exc = '0;
        commit_exccode = '0; commit_badv_we = '0; commit_badv = '0; commit_eret = '0;
        int_pending = 1'b0; cp0_exl = 1'b0; cp0_epc = '0;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        clearInputs();
        nextCycle();
        nextCycle();
        commit_valid = 2'b11; commit_exc = 2'b01;
        settle();
        checks++; if (cp0_excp_we !== 1'b0) begin failures++; $display("[TB] FAIL rst_excp_we got=%b want=0", cp0_excp_we); end
        checks++; if (commit_kill !== 2'b00) begin failures++; $display("[TB] FAIL rst_kill got=%b want=00", commit_kill); end
        nextCycle();
        reset = 1'b0;
        clearInputs();
        settle();
        checks++; if (flush !== 1'b0) begin failures++; $display("[TB] FAIL rst_flush got=%b want=0", flush); end
        checks++; if (redirect_valid !== 1'b0) begin failures++; $display("[TB] FAIL rst_redir_valid got=%b want=0", redirect_valid); end
        checks++; if (redirect_pc !== 32'd0) begin failures++; $display("[TB] FAIL rst_redir_pc got=%h want=0", redirect_pc); end
        nextCycle();
    endtask

    task automatic test_exception();
        clearInputs();
        commit_valid = 2'b11; commit_pc = {32'h8000_1004, 32'h8000_1000};
        commit_exc = 2'b01; commit_exccode = {5'd0, 5'd12};
        settle();
        checks++; if (commit_kill !== 2'b11) begin failures++; $display("[TB] FAIL exc_kill got=%b want=11", commit_kill); end
        checks++; if (cp0_excp_we !== 1'b1) begin failures++; $display("[TB] FAIL exc_we got=%b want=1", cp0_excp_we); end
        checks++; if (cp0_exccode !== 5'd12) begin failures++; $display("[TB] FAIL exc_code got=%0d want=12", cp0_exccode); end
        checks++; if (cp0_epc_wd !== 32'h8000_1000) begin failures++; $display("[TB] FAIL exc_epc got=%h want=80001000", cp0_epc_wd); end
        checks++; if (cp0_bd !== 1'b0) begin failures++; $display("[TB] FAIL exc_bd got=%b want=0", cp0_bd); end
        nextCycle();
        clearInputs();
        commit_valid = 2'b11; commit_exc = 2'b01;
        settle();
        checks++; if (flush !== 1'b1) begin failures++; $display("[TB] FAIL exc_flush got=%b want=1", flush); end
        checks++; if (redirect_valid !== 1'b1) begin failures++; $display("[TB] FAIL exc_redir_valid got=%b want=1", redirect_valid); end
        checks++; if (redirect_pc !== 32'hBFC0_0380) begin failures++; $display("[TB] FAIL exc_redir_pc got=%h want=bfc00380", redirect_pc); end
        checks++; if (commit_kill !== 2'b11) begin failures++; $display("[TB] FAIL exc_flush_kill got=%b want=11", commit_kill); end
        checks++; if (cp0_excp_we !== 1'b0) begin failures++; $display("[TB] FAIL exc_flush_we got=%b want=0", cp0_excp_we); end
        nextCycle();
        clearInputs();
        settle();
        checks++; if (flush !== 1'b0) begin failures++; $display("[TB] FAIL exc_flush_end got=%b want=0", flush); end
        nextCycle();
    endtask

    task automatic test_delay_slot();
        clearInputs();
        commit_valid = 2'b11; commit_pc = {32'h104, 32'h100}; commit_in_ds = 2'b10;
        commit_exc = 2'b10; commit_exccode = {5'd4, 5'd0};
        commit_badv_we = 2'b10; commit_badv = {32'h3, 32'h0};
        settle();
        checks++; if (commit_kill !== 2'b10) begin failures++; $display("[TB] FAIL ds_kill got=%b want=10", commit_kill); end
        checks++; if (cp0_epc_wd !== 32'h100) begin failures++; $display("[TB] FAIL ds_epc got=%h want=100", cp0_epc_wd); end
        checks++; if (cp0_bd !== 1'b1) begin failures++; $display("[TB] FAIL ds_bd got=%b want=1", cp0_bd); end
        checks++; if (cp0_exccode !== 5'd4) begin failures++; $display("[TB] FAIL ds_code got=%0d want=4", cp0_exccode); end
        checks++; if (cp0_badv_we !== 1'b1) begin failures++; $display("[TB] FAIL ds_badv_we got=%b want=1", cp0_badv_we); end
        checks++; if (cp0_badv_wd !== 32'h3) begin failures++; $display("[TB] FAIL ds_badv got=%h want=3", cp0_badv_wd); end
        nextCycle();
        clearInputs();
        nextCycle();
    endtask

    task automatic test_int_priority();
        clearInputs();
        int_pending = 1'b1; commit_valid = 2'b01; commit_pc = {32'h0, 32'h200}; commit_eret = 2'b01;
        commit_badv_we = 2'b01; commit_badv = {32'h0, 32'hDEAD};
        settle();
        checks++; if (cp0_excp_we !== 1'b1) begin failures++; $display("[TB] FAIL int_we got=%b want=1", cp0_excp_we); end
        checks++; if (cp0_exccode !== 5'd0) begin failures++; $display("[TB] FAIL int_code got=%0d want=0", cp0_exccode); end
        checks++; if (cp0_epc_wd !== 32'h200) begin failures++; $display("[TB] FAIL int_epc got=%h want=200", cp0_epc_wd); end
        checks++; if (cp0_eret !== 1'b0) begin failures++; $display("[TB] FAIL int_eret got=%b want=0", cp0_eret); end
        checks++; if (cp0_badv_we !== 1'b0) begin failures++; $display("[TB] FAIL int_badv_we got=%b want=0", cp0_badv_we); end
        checks++; if (commit_kill !== 2'b01) begin failures++; $display("[TB] FAIL int_kill got=%b want=01", commit_kill); end
        nextCycle();
        clearInputs();
        settle();
        checks++; if (redirect_pc !== 32'hBFC0_0380) begin failures++; $display("[TB] FAIL int_redir_pc got=%h want=bfc00380", redirect_pc); end
        nextCycle();
    endtask

    task automatic test_eret();
        clearInputs();
        commit_valid = 2'b11; commit_pc = {32'h404, 32'h400}; commit_eret = 2'b01;
        cp0_epc = 32'h8000_2000;
        settle();
        checks++; if (cp0_eret !== 1'b1) begin failures++; $display("[TB] FAIL eret_cmd got=%b want=1", cp0_eret); end
        checks++; if (cp0_excp_we !== 1'b0) begin failures++; $display("[TB] FAIL eret_we got=%b want=0", cp0_excp_we); end
        checks++; if (commit_kill !== 2'b11) begin failures++; $display("[TB] FAIL eret_kill got=%b want=11", commit_kill); end
        nextCycle();
        clearInputs();
        settle();
        checks++; if (flush !== 1'b1) begin failures++; $display("[TB] FAIL eret_flush got=%b want=1", flush); end
        checks++; if (redirect_pc !== 32'h8000_2000) begin failures++; $display("[TB] FAIL eret_redir_pc got=%h want=80002000", redirect_pc); end
        nextCycle();
    endtask

    task automatic test_deferred_int();
        clearInputs();
        commit_valid = 2'b01; commit_pc = {32'h0, 32'h300};
        settle();
        checks++; if (commit_kill !== 2'b00) begin failures++; $display("[TB] FAIL defer_retire_kill got=%b want=00", commit_kill); end
        nextCycle();
        clearInputs();
        int_pending = 1'b1;
        // One idle cycle to notice the interrupt, then DEFER_MAX-1 waiting cycles.
        for (int i = 0; i < DEFER_MAX; i++) begin
            settle();
            checks++; if (cp0_excp_we !== 1'b0) begin failures++; $display("[TB] FAIL defer_wait%0d got=%b want=0", i, cp0_excp_we); end
            nextCycle();
        end
        settle();
        checks++; if (cp0_excp_we !== 1'b1) begin failures++; $display("[TB] FAIL defer_we got=%b want=1", cp0_excp_we); end
        checks++; if (cp0_epc_wd !== 32'h304) begin failures++; $display("[TB] FAIL defer_epc got=%h want=304", cp0_epc_wd); end
        checks++; if (cp0_bd !== 1'b0) begin failures++; $display("[TB] FAIL defer_bd got=%b want=0", cp0_bd); end
        checks++; if (cp0_exccode !== 5'd0) begin failures++; $display("[TB] FAIL defer_code got=%0d want=0", cp0_exccode); end
        nextCycle();
        int_pending = 1'b0;
        settle();
        checks++; if (flush !== 1'b1) begin failures++; $display("[TB] FAIL defer_flush got=%b want=1", flush); end
        nextCycle();
    endtask

    task automatic test_reset_in_flush();
        clearInputs();
        commit_valid = 2'b01; commit_exc = 2'b01; reset = 1'b1;
        settle();
        checks++; if (cp0_excp_we !== 1'b0) begin failures++; $display("[TB] FAIL rstev_we got=%b want=0", cp0_excp_we); end
        nextCycle();
        reset = 1'b0;
        clearInputs();
        settle();
        checks++; if (flush !== 1'b0) begin failures++; $display("[TB] FAIL rstev_flush got=%b want=0", flush); end
        commit_valid = 2'b01; commit_exc = 2'b01;
        nextCycle();
        clearInputs();
        settle();
        checks++; if (flush !== 1'b1) begin failures++; $display("[TB] FAIL rstfl_pre got=%b want=1", flush); end
        reset = 1'b1;
        settle();
        checks++; if (commit_kill !== 2'b00) begin failures++; $display("[TB] FAIL rstfl_kill got=%b want=00", commit_kill); end
        nextCycle();
        reset = 1'b0;
        settle();
        checks++; if (flush !== 1'b0) begin failures++; $display("[TB] FAIL rstfl_flush got=%b want=0", flush); end
        checks++; if (redirect_valid !== 1'b0) begin failures++; $display("[TB] FAIL rstfl_redir_valid got=%b want=0", redirect_valid); end
        checks++; if (redirect_pc !== 32'd0) begin failures++; $display("[TB] FAIL rstfl_redir_pc got=%h want=0", redirect_pc); end
        commit_valid = 2'b01; commit_exc = 2'b01;
        settle();
        checks++; if (cp0_excp_we !== 1'b1) begin failures++; $display("[TB] FAIL rstfl_idle_we got=%b want=1", cp0_excp_we); end
        nextCycle();
        clearInputs();
        nextCycle();
    endtask

    // Expected combinational response: oldest event by age, interrupts bind to the
    // oldest valid instruction, otherwise a waited-out interrupt resumes after last PC.
    task automatic modelExpect();
        int          k;
        bit          isInt, isExc;
        logic [31:0] pc;
        k = -1; isInt = 1'b0; isExc = 1'b0;
        eKill = 2'b00; eWe = 1'b0; eEret = 1'b0; eBd = 1'b0; eBadvWe = 1'b0;
        eEvent = 1'b0; eCode = 5'd0; eEpc = 32'd0; eBadv = 32'd0;
        if (mInFlush) begin
            eKill = 2'b11;
        end else begin
            if (int_pending)
                for (int s = 0; s < 2; s++)
                    if (k < 0 && commit_valid[s]) begin k = s; isInt = 1'b1; end
            if (k < 0)
                for (int s = 0; s < 2; s++)
                    if (k < 0 && commit_valid[s] && (commit_exc[s] || commit_eret[s])) begin
                        k = s; isExc = commit_exc[s];
                    end
            if (k >= 0) begin
                eEvent = 1'b1;
                for (int j = k; j < 2; j++) eKill[j] = commit_valid[j];
                if (isInt || isExc) begin
                    pc   = commit_pc[k*32 +: 32];
                    eWe  = 1'b1;
                    eBd  = commit_in_ds[k];
                    eEpc = commit_in_ds[k] ? pc - 32'd4 : pc;
                    eCode = isInt ? 5'd0 : commit_exccode[k*5 +: 5];
                    if (isExc) begin
                        eBadvWe = commit_badv_we[k];
                        eBadv   = commit_badv[k*32 +: 32];
                    end
                end else begin
                    eEret = 1'b1;
                end
            end else if (int_pending && mWait == DEFER_MAX - 1) begin
                eEvent = 1'b1; eWe = 1'b1; eEpc = mLastPc + 32'd4;
            end
        end
    endtask

    task automatic modelAdvance();
        logic [1:0] retire;
        if (!mInFlush) begin
            retire = commit_valid & ~eKill;
            if (retire[1]) mLastPc = commit_pc[63:32];
            else if (retire[0]) mLastPc = commit_pc[31:0];
        end
        mFlush = eEvent;
        if (eEvent) mRedirPc = eEret ? cp0_epc : 32'hBFC0_0380;
        if (!eEvent && !mInFlush && int_pending && commit_valid == 2'b00) mWait = mWait + 1;
        else mWait = -1;
        mInFlush = eEvent;
    endtask

    task automatic test_random();
        bit intLevel, quiet;
        reset = 1'b1;
        clearInputs();
        nextCycle();
        reset = 1'b0;
        mInFlush = 1'b0; mWait = -1; mLastPc = 32'hBFC0_0000; mFlush = 1'b0; mRedirPc = 32'd0;
        intLevel = 1'b0; quiet = 1'b0;
        for (int cyc = 0; cyc < 800; cyc++) begin
            if (cyc % 40 == 0) quiet = ($urandom_range(0, 1) == 1);
            if ($urandom_range(0, 19) == 0) intLevel = ~intLevel;
            int_pending    = intLevel;
            commit_valid   = quiet ? 2'b00 : 2'($urandom_range(0, 3));
            commit_pc      = {$urandom, $urandom};
            commit_in_ds   = 2'($urandom_range(0, 3));
            commit_exc     = {($urandom_range(0, 4) == 0), ($urandom_range(0, 4) == 0)};
            commit_eret    = {($urandom_range(0, 6) == 0), ($urandom_range(0, 6) == 0)};
            commit_exccode = 10'($urandom);
            commit_badv_we = 2'($urandom_range(0, 3));
            commit_badv    = {$urandom, $urandom};
            cp0_exl        = ($urandom_range(0, 1) == 1);
            cp0_epc        = $urandom;
            settle();
            modelExpect();
            checks++; if (commit_kill !== eKill) begin failures++; $display("[TB] FAIL rnd_kill cyc=%0d got=%b want=%b", cyc, commit_kill, eKill); end
            checks++; if (cp0_excp_we !== eWe) begin failures++; $display("[TB] FAIL rnd_we cyc=%0d got=%b want=%b", cyc, cp0_excp_we, eWe); end
            checks++; if (cp0_eret !== eEret) begin failures++; $display("[TB] FAIL rnd_eret cyc=%0d got=%b want=%b", cyc, cp0_eret, eEret); end
            checks++; if (flush !== mFlush) begin failures++; $display("[TB] FAIL rnd_flush cyc=%0d got=%b want=%b", cyc, flush, mFlush); end
            checks++; if (redirect_valid !== mFlush) begin failures++; $display("[TB] FAIL rnd_redir_valid cyc=%0d got=%b want=%b", cyc, redirect_valid, mFlush); end
            if (mFlush) begin
                checks++; if (redirect_pc !== mRedirPc) begin failures++; $display("[TB] FAIL rnd_redir_pc cyc=%0d got=%h want=%h", cyc, redirect_pc, mRedirPc); end
            end
            if (eWe) begin
                checks++; if (cp0_exccode !== eCode) begin failures++; $display("[TB] FAIL rnd_code cyc=%0d got=%0d want=%0d", cyc, cp0_exccode, eCode); end
                checks++; if (cp0_epc_wd !== eEpc) begin failures++; $display("[TB] FAIL rnd_epc cyc=%0d got=%h want=%h", cyc, cp0_epc_wd, eEpc); end
                checks++; if (cp0_bd !== eBd) begin failures++; $display("[TB] FAIL rnd_bd cyc=%0d got=%b want=%b", cyc, cp0_bd, eBd); end
                checks++; if (cp0_badv_we !== eBadvWe) begin failures++; $display("[TB] FAIL rnd_badv_we cyc=%0d got=%b want=%b", cyc, cp0_badv_we, eBadvWe); end
                checks++; if (cp0_badv_wd !== eBadv) begin failures++; $display("[TB] FAIL rnd_badv cyc=%0d got=%h want=%h", cyc, cp0_badv_wd, eBadv); end
            end
            modelAdvance();
            nextCycle();
        end
    endtask

    initial begin
        test_reset();
        test_exception();
        test_delay_slot();
        test_int_priority();
        test_eret();
        test_deferred_int();
        test_reset_in_flush();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
